skolem_bvugt_bvashr_seq: RTL and testbench

Sequential, parametrised witness generator for the bvugt/bvashr invertibility condition, for either operand position. It accepts (s, t) over a valid/ready request channel and sweeps candidates x in ascending order, one per cycle. It returns the minimal x satisfying the predicate, or not-found, over a valid/ready response channel. It is the clocked successor to the fixed-width combinational Skolem netlists and is used by the solver-side checker to produce concrete models.

---
 rtl/skolem_pkg.sv | 68 ++++++
 rtl/skolem_bvugt_bvashr_eval.sv | 35 +++
 rtl/skolem_bvugt_bvashr_seq.sv | 127 ++++++++++++
 tb/tb_skolem_bvugt_bvashr_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/skolem_pkg.sv
// Shared types and bit-vector helpers for the bvugt/bvashr Skolem witness generator.
// Helpers work on a fixed MAX_W-bit container; callers pass the live width w.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam int unsigned POS_X_SHIFTED = 0;
  localparam int unsigned POS_X_AMOUNT  = 1;
  localparam int unsigned MAX_W         = 16;

  // Arithmetic shift right of the low w bits of value; amounts >= w saturate to w sign copies.
  function automatic logic [MAX_W-1:0] ashr_sat(
    input logic [MAX_W-1:0] value,
    input logic [MAX_W:0]   amount,
    input int unsigned      w
  );
    logic [MAX_W-1:0] r;
    logic [3:0]       wi;
    logic             sign;
    int unsigned      idx;
    wi   = 4'(w - 1);
    sign = value[wi];
    r    = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        idx = i + 32'(amount);
        if (idx < w) r[i] = value[idx[3:0]];
        else         r[i] = sign;
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Closed-form invertibility condition: a witness exists iff this returns 1.
  function automatic logic ic_bvugt_bvashr(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] t,
    input int unsigned      pos,
    input int unsigned      w
  );
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] sm;
    logic [MAX_W-1:0] tm;
    logic [MAX_W-1:0] sh;
    m  = width_mask(w);
    sm = s & m;
    tm = t & m;
    if (pos == POS_X_SHIFTED) begin
      return tm != m;
    end
    sh = ashr_sat(sm, 17'(w - 1), w) & m;
    return (sm > tm) || (sh > tm);
  endfunction

endpackage

// File: rtl/skolem_bvugt_bvashr_eval.sv
// Combinational candidate evaluator: pred = (a >>a b) >u t, operand roles chosen by POS.
module skolem_bvugt_bvashr_eval
  import skolem_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned POS = POS_X_SHIFTED
) (
  input  logic [W-1:0] cand,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         pred
);

  logic [MAX_W-1:0] a;
  logic [MAX_W:0]   b;
  logic [MAX_W-1:0] tw;
  logic [MAX_W-1:0] r;

  always_comb begin
    a        = '0;
    b        = '0;
    tw       = '0;
    tw[W-1:0] = t;
    if (POS == POS_X_SHIFTED) begin
      a[W-1:0] = cand;
      b[W-1:0] = s;
    end else begin
      a[W-1:0] = s;
      b[W-1:0] = cand;
    end
    r    = ashr_sat(a, b, W);
    pred = r > tw;
  end

endmodule

// File: rtl/skolem_bvugt_bvashr_seq.sv
// Sequential minimal-witness search for bvugt/bvashr, one candidate per cycle.
// Optional build macro SKOLEM_IC_EARLY_EXIT_EN rejects unsatisfiable queries at accept.
module skolem_bvugt_bvashr_seq
  import skolem_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned POS = POS_X_SHIFTED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_s,
  input  logic [W-1:0] req_t,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_found,
  output logic [W-1:0] resp_witness,
  output logic [W:0]   resp_iters
);

  localparam logic [W:0] LAST_CAND = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ALL_CANDS = {1'b1, {W{1'b0}}};

  state_t       state, state_n;
  logic [W-1:0] s_q, s_n;
  logic [W-1:0] t_q, t_n;
  logic [W:0]   cnt, cnt_n;
  logic         found_n;
  logic [W-1:0] witness_n;
  logic [W:0]   iters_n;
  logic         pred;

  skolem_bvugt_bvashr_eval #(
    .W  (W),
    .POS(POS)
  ) u_eval (
    .cand(cnt[W-1:0]),
    .s   (s_q),
    .t   (t_q),
    .pred(pred)
  );

`ifdef SKOLEM_IC_EARLY_EXIT_EN
  logic [MAX_W-1:0] ic_s;
  logic [MAX_W-1:0] ic_t;
  logic             ic;

  always_comb begin
    ic_s        = '0;
    ic_t        = '0;
    ic_s[W-1:0] = req_s;
    ic_t[W-1:0] = req_t;
    ic          = ic_bvugt_bvashr(ic_s, ic_t, POS, W);
  end
`endif

  always_comb begin
    state_n   = state;
    s_n       = s_q;
    t_n       = t_q;
    cnt_n     = cnt;
    found_n   = resp_found;
    witness_n = resp_witness;
    iters_n   = resp_iters;
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          s_n     = req_s;
          t_n     = req_t;
          cnt_n   = '0;
          state_n = SEARCH;
`ifdef SKOLEM_IC_EARLY_EXIT_EN
          if (!ic) begin
            state_n   = DONE;
            found_n   = 1'b0;
            witness_n = '0;
            iters_n   = '0;
          end
`endif
        end
      end
      SEARCH: begin
        if (pred) begin
          state_n   = DONE;
          found_n   = 1'b1;
          witness_n = cnt[W-1:0];
          iters_n   = cnt + 1'b1;
        end else if (cnt == LAST_CAND) begin
          state_n   = DONE;
          found_n   = 1'b0;
          witness_n = '0;
          iters_n   = ALL_CANDS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_q          <= '0;
      t_q          <= '0;
      cnt          <= '0;
      resp_found   <= 1'b0;
      resp_witness <= '0;
      resp_iters   <= '0;
    end else begin
      state        <= state_n;
      s_q          <= s_n;
      t_q          <= t_n;
      cnt          <= cnt_n;
      resp_found   <= found_n;
      resp_witness <= witness_n;
      resp_iters   <= iters_n;
    end
  end

endmodule

// File: tb/tb_skolem_bvugt_bvashr_seq.sv
// Directed bench for skolem_bvugt_bvashr_seq, W=4, one instance per operand position.
module tb_skolem_bvugt_bvashr_seq;

  localparam int unsigned W = 4;

`ifdef SKOLEM_IC_EARLY_EXIT_EN
  localparam int         NF_LAT   = 1;
  localparam logic [4:0] NF_ITERS = 5'd0;
`else
  localparam int         NF_LAT   = 17;
  localparam logic [4:0] NF_ITERS = 5'd16;
`endif

  logic         clk;
  logic         rst;
  logic         req_valid    [2];
  logic         req_ready    [2];
  logic [W-1:0] req_s        [2];
  logic [W-1:0] req_t        [2];
  logic         resp_valid   [2];
  logic         resp_ready   [2];
  logic         resp_found   [2];
  logic [W-1:0] resp_witness [2];
  logic [W:0]   resp_iters   [2];

  int errors = 0;
  int checks = 0;

  skolem_bvugt_bvashr_seq #(.W(W), .POS(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_s(req_s[0]), .req_t(req_t[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_found(resp_found[0]), .resp_witness(resp_witness[0]),
    .resp_iters(resp_iters[0])
  );

  skolem_bvugt_bvashr_seq #(.W(W), .POS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_s(req_s[1]), .req_t(req_t[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_found(resp_found[1]), .resp_witness(resp_witness[1]),
    .resp_iters(resp_iters[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int p, input string tag, input logic ef,
                            input logic [3:0] ew, input logic [4:0] ei);
    check({tag, "_req_ready"},  32'(req_ready[p]), 1);
    check({tag, "_resp_valid"}, 32'(resp_valid[p]), 0);
    check({tag, "_found"},      32'(resp_found[p]), 32'(ef));
    check({tag, "_witness"},    32'(resp_witness[p]), 32'(ew));
    check({tag, "_iters"},      32'(resp_iters[p]), 32'(ei));
  endtask

  // Cycle 0 is the accept cycle; latency is the cycle in which resp_valid is first seen.
  task automatic run(input int p, input logic [3:0] s, input logic [3:0] t,
                     input logic ef, input logic [3:0] ew, input logic [4:0] ei,
                     input int elat, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, "_accept_ready"}, 32'(req_ready[p]), 1);
    req_s[p] = s; req_t[p] = t; req_valid[p] = 1'b1; resp_ready[p] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0; req_s[p] = ~s; req_t[p] = ~t;
    cyc = 1;
    @(negedge clk);
    while (!resp_valid[p] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(elat));
    check({tag, "_found"},   32'(resp_found[p]), 32'(ef));
    check({tag, "_witness"}, 32'(resp_witness[p]), 32'(ew));
    check({tag, "_iters"},   32'(resp_iters[p]), 32'(ei));
    @(negedge clk);
    check_idle(p, {tag, "_post"}, ef, ew, ei);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_s[i] = '0; req_t[i] = '0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle(0, "rst0", 1'b0, 4'd0, 5'd0);
    check_idle(1, "rst1", 1'b0, 4'd0, 5'd0);

    run(0, 4'd2, 4'd15, 1'b0, 4'd0, NF_ITERS, NF_LAT, "c2_nf");
    run(0, 4'd1, 4'd6,  1'b1, 4'd8, 5'd9,     10,     "c1_hit8");
    run(1, 4'b1000, 4'd13, 1'b1, 4'd2, 5'd3,  4,      "c3_hit2");
    run(1, 4'd3, 4'd3,  1'b0, 4'd0, NF_ITERS, NF_LAT, "c4_nf");
    run(0, 4'd0, 4'd0,  1'b1, 4'd1, 5'd2,     3,      "p0_x1");

    // Backpressure: hold resp_ready low for 5 cycles of DONE, poke req_valid meanwhile.
    @(negedge clk);
    resp_ready[1] = 1'b0;
    req_s[1] = 4'b1000; req_t[1] = 4'd13; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!resp_valid[1] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 32'(cyc), 4);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid",     32'(resp_valid[1]), 1);
      check("bp_req_ready", 32'(req_ready[1]), 0);
      check("bp_found",     32'(resp_found[1]), 1);
      check("bp_witness",   32'(resp_witness[1]), 2);
      check("bp_iters",     32'(resp_iters[1]), 3);
      if (k == 1) begin
        req_s[1] = 4'd0; req_t[1] = 4'd0; req_valid[1] = 1'b1;
      end else begin
        req_valid[1] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    check_idle(1, "bp_post", 1'b1, 4'd2, 5'd3);

    // Reset in cycle 3 of a POS=0 search that would hit at x=8.
    @(negedge clk);
    req_s[0] = 4'd1; req_t[0] = 4'd6; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle(0, "mid_rst0", 1'b0, 4'd0, 5'd0);
    check_idle(1, "mid_rst1", 1'b0, 4'd0, 5'd0);
    run(1, 4'b1000, 4'd13, 1'b1, 4'd2, 5'd3, 4, "c6_after_rst");
    run(0, 4'd1, 4'd6, 1'b1, 4'd8, 5'd9, 10, "c6_p0_again");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
